mtimer_multi: RTL

Parametrised machine-timer block: one free-running CNT_W-bit `mtime` counter with a programmable prescaler, plus NUM_CMP independent `mtimecmp` comparator channels, each with its own interrupt enable and registered level interrupt. It is accessed through a simple 32-bit single-cycle register port and drives the core's timer interrupt lines. This is the successor to the single-comparator, always-incrementing timer: it adds multiple channels, a prescaler, a global enable, and tear-free 64-bit reads.

---
 rtl/mtimer_pkg.sv | 17 +
 rtl/mtimer_cmp.sv | 41 ++++
 rtl/mtimer_multi.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mtimer_pkg.sv
// rtl/mtimer_pkg.sv - register map and reset constants for the multi-channel machine timer
package mtimer_pkg;

  localparam logic [7:0] ADDR_MTIME_LO = 8'h00;
  localparam logic [7:0] ADDR_MTIME_HI = 8'h04;
  localparam logic [7:0] ADDR_CTRL     = 8'h08;
  localparam logic [7:0] ADDR_PRESC    = 8'h0C;
  localparam logic [7:0] ADDR_IRQ_EN   = 8'h10;
  localparam logic [7:0] ADDR_IRQ_PEND = 8'h14;
  localparam logic [7:0] ADDR_CMP_BASE = 8'h20;

  localparam int CTRL_EN_BIT = 0;

  localparam logic [63:0] CMP_RST    = '1;
  localparam logic [7:0]  IRQ_EN_RST = '1;

endpackage

// File: rtl/mtimer_cmp.sv
// rtl/mtimer_cmp.sv - one mtimecmp channel: compare register, comparator, registered gated interrupt
module mtimer_cmp
  import mtimer_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_lo,
  input  logic             we_hi,
  input  logic [31:0]      wdata,
  input  logic [CNT_W-1:0] mtime,
  input  logic             irq_en,
  output logic [CNT_W-1:0] cmp,
  output logic             irq
);

  logic [63:0] cmp64;
  logic [63:0] cmp_lo_wr;
  logic [63:0] cmp_hi_wr;

  // Halves are merged at 64 bits so the same code serves CNT_W of 32 or 64.
  assign cmp64     = 64'(cmp);
  assign cmp_lo_wr = {cmp64[63:32], wdata};
  assign cmp_hi_wr = {wdata, cmp64[31:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp <= CMP_RST[CNT_W-1:0];
      irq <= 1'b0;
    end else begin
      if (we_lo) begin
        cmp <= cmp_lo_wr[CNT_W-1:0];
      end else if (we_hi) begin
        cmp <= cmp_hi_wr[CNT_W-1:0];
      end
      irq <= (mtime >= cmp) & irq_en;
    end
  end

endmodule

// File: rtl/mtimer_multi.sv
// rtl/mtimer_multi.sv - machine timer with prescaler, global enable, tear-free reads and NUM_CMP compare channels
module mtimer_multi
  import mtimer_pkg::*;
#(
  parameter int NUM_CMP = 4,
  parameter int CNT_W   = 64,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [7:0]         req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic [NUM_CMP-1:0] timer_irq,
  output logic [CNT_W-1:0]   mtime_o
);

  localparam logic [5:0] W_MTIME_LO = ADDR_MTIME_LO[7:2];
  localparam logic [5:0] W_MTIME_HI = ADDR_MTIME_HI[7:2];
  localparam logic [5:0] W_CTRL     = ADDR_CTRL[7:2];
  localparam logic [5:0] W_PRESC    = ADDR_PRESC[7:2];
  localparam logic [5:0] W_IRQ_EN   = ADDR_IRQ_EN[7:2];
  localparam logic [5:0] W_IRQ_PEND = ADDR_IRQ_PEND[7:2];
  localparam logic [5:0] W_CMP_BASE = ADDR_CMP_BASE[7:2];
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PRESC_W-1:0] PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]   mtime;
  logic [PRESC_W-1:0] pcnt;
  logic [PRESC_W-1:0] presc;
  logic               en;
  logic [NUM_CMP-1:0] irq_en;
  logic [31:0]        shadow;

  logic [5:0]  widx;
  logic        wr_en;
  logic        rd_en;
  logic        we_lo;
  logic        we_hi;
  logic        we_ctrl;
  logic        we_presc;
  logic        we_irq_en;
  logic        tick;
  logic [63:0] mtime64;
  logic [63:0] mtime_lo_wr;
  logic [63:0] mtime_hi_wr;
  logic [31:0] rdata_mux;
  logic [1:0]  unused_addr_lsb;

  logic [CNT_W-1:0] cmp_val [NUM_CMP];

  assign widx            = req_addr[7:2];
  assign unused_addr_lsb = req_addr[1:0];
  assign wr_en           = req_valid & req_we;
  assign rd_en           = req_valid & ~req_we;

  assign we_lo     = wr_en && (widx == W_MTIME_LO);
  assign we_hi     = wr_en && (widx == W_MTIME_HI) && (CNT_W == 64);
  assign we_ctrl   = wr_en && (widx == W_CTRL);
  assign we_presc  = wr_en && (widx == W_PRESC);
  assign we_irq_en = wr_en && (widx == W_IRQ_EN);

  assign tick        = en && (pcnt == presc);
  assign mtime64     = 64'(mtime);
  assign mtime_lo_wr = {mtime64[63:32], req_wdata};
  assign mtime_hi_wr = {req_wdata, mtime64[31:0]};
  assign mtime_o     = mtime;

  // A software write to either mtime half wins over a same-cycle tick and restarts the prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime     <= '0;
      pcnt      <= '0;
      presc     <= '0;
      en        <= 1'b1;
      irq_en    <= IRQ_EN_RST[NUM_CMP-1:0];
      shadow    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (we_lo) begin
        mtime <= mtime_lo_wr[CNT_W-1:0];
      end else if (we_hi) begin
        mtime <= mtime_hi_wr[CNT_W-1:0];
      end else if (tick) begin
        mtime <= mtime + CNT_ONE;
      end

      if (we_lo || we_hi || we_presc) begin
        pcnt <= '0;
      end else if (en) begin
        pcnt <= tick ? '0 : pcnt + PRESC_ONE;
      end

      if (we_presc)  presc  <= req_wdata[PRESC_W-1:0];
      if (we_ctrl)   en     <= req_wdata[CTRL_EN_BIT];
      if (we_irq_en) irq_en <= req_wdata[NUM_CMP-1:0];

      // Latching the upper half on a low read lets software assemble a consistent 64-bit value.
      if (rd_en && (widx == W_MTIME_LO)) shadow <= mtime64[63:32];

      rsp_valid <= rd_en;
      if (rd_en) rsp_rdata <= rdata_mux;
    end
  end

  always_comb begin
    logic [63:0] c64;
    rdata_mux = '0;
    c64       = '0;
    case (widx)
      W_MTIME_LO: rdata_mux = mtime64[31:0];
      W_MTIME_HI: rdata_mux = shadow;
      W_CTRL:     rdata_mux[CTRL_EN_BIT] = en;
      W_PRESC:    rdata_mux[PRESC_W-1:0] = presc;
      W_IRQ_EN:   rdata_mux[NUM_CMP-1:0] = irq_en;
      W_IRQ_PEND: rdata_mux[NUM_CMP-1:0] = timer_irq;
      default:    rdata_mux = '0;
    endcase
    for (int i = 0; i < NUM_CMP; i++) begin
      c64 = 64'(cmp_val[i]);
      if (widx == 6'(W_CMP_BASE + 6'(2 * i)))     rdata_mux = c64[31:0];
      if (widx == 6'(W_CMP_BASE + 6'(2 * i + 1))) rdata_mux = c64[63:32];
    end
  end

  for (genvar i = 0; i < NUM_CMP; i++) begin : g_cmp
    logic lo_we;
    logic hi_we;
    assign lo_we = wr_en && (widx == 6'(W_CMP_BASE + 6'(2 * i)));
    assign hi_we = wr_en && (widx == 6'(W_CMP_BASE + 6'(2 * i + 1))) && (CNT_W == 64);

    mtimer_cmp #(.CNT_W(CNT_W)) u_cmp (
      .clk    (clk),
      .rst_n  (rst_n),
      .we_lo  (lo_we),
      .we_hi  (hi_we),
      .wdata  (req_wdata),
      .mtime  (mtime),
      .irq_en (irq_en[i]),
      .cmp    (cmp_val[i]),
      .irq    (timer_irq[i])
    );
  end

endmodule
